// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: nickel-unit credit, one-hot product vend, greedy one-coin-per-cycle change.
// Optional refund path is compiled in with `define REFUND_EN.
module vend_fsm_param #(
    parameter int NUM_PRODUCTS = 2,
    parameter int PRICE        = 9,
    parameter int MAX_CREDIT   = 20,
    parameter int CREDIT_W     = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    coin_nickel,
    input  logic                    coin_dime,
    input  logic                    coin_quarter,
    input  logic [NUM_PRODUCTS-1:0] sel,
`ifdef REFUND_EN
    input  logic                    refund,
`endif
    output logic [NUM_PRODUCTS-1:0] vend_valid,
    output logic                    change_nickel,
    output logic                    change_dime,
    output logic                    change_quarter,
    output logic                    coin_reject,
    output logic [CREDIT_W-1:0]     credit,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    // Greedy change step: returns {quarter, dime, nickel, remainder after this coin}.
    function automatic logic [CREDIT_W+2:0] change_step(input logic [CREDIT_W-1:0] rem);
        if (rem >= CREDIT_W'(5))
            return {3'b100, rem - CREDIT_W'(5)};
        else if (rem >= CREDIT_W'(2))
            return {3'b010, rem - CREDIT_W'(2)};
        else
            return {3'b001, rem - CREDIT_W'(1)};
    endfunction

    state_t                  state, state_n;
    logic [CREDIT_W-1:0]     remainder, remainder_n, credit_n;
    logic [NUM_PRODUCTS-1:0] vend_n;
    logic                    cn_n, cd_n, cq_n, reject_n, busy_n;

    logic                    any_coin, one_coin, sel_ok;
    logic [CREDIT_W:0]       coin_val, credit_sum;
    logic [CREDIT_W+2:0]     step_rem;

    assign any_coin   = coin_nickel | coin_dime | coin_quarter;
    assign one_coin   = ({1'b0, coin_nickel} + {1'b0, coin_dime} + {1'b0, coin_quarter}) == 2'd1;
    assign coin_val   = coin_quarter ? (CREDIT_W+1)'(5) :
                        coin_dime    ? (CREDIT_W+1)'(2) : (CREDIT_W+1)'(1);
    assign credit_sum = {1'b0, credit} + coin_val;
    // sel is judged against credit before this cycle's coin lands
    assign sel_ok     = $onehot(sel) && (credit >= PRICE_C);
    assign step_rem   = change_step(remainder);

`ifdef REFUND_EN
    logic [CREDIT_W+2:0] step_cr;
    assign step_cr = change_step(credit);
`endif

    always_comb begin
        state_n     = state;
        credit_n    = credit;
        remainder_n = remainder;
        vend_n      = '0;
        cq_n        = 1'b0;
        cd_n        = 1'b0;
        cn_n        = 1'b0;
        reject_n    = 1'b0;
        case (state)
            IDLE, CREDIT: begin
                if (sel_ok) begin
                    state_n     = VEND;
                    remainder_n = credit - PRICE_C;
                    credit_n    = '0;
                    vend_n      = sel;
                    reject_n    = any_coin;
`ifdef REFUND_EN
                end else if (state == CREDIT && refund) begin
                    // first change coin goes out in the cycle CHANGE is entered
                    state_n            = CHANGE;
                    credit_n           = '0;
                    {cq_n, cd_n, cn_n} = step_cr[CREDIT_W+2:CREDIT_W];
                    remainder_n        = step_cr[CREDIT_W-1:0];
                    reject_n           = any_coin;
`endif
                end else if (any_coin) begin
                    if (one_coin && credit_sum <= MAX_C) begin
                        credit_n = credit_sum[CREDIT_W-1:0];
                        state_n  = CREDIT;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end
            VEND, CHANGE: begin
                reject_n = any_coin;
                if (remainder != '0) begin
                    state_n            = CHANGE;
                    {cq_n, cd_n, cn_n} = step_rem[CREDIT_W+2:CREDIT_W];
                    remainder_n        = step_rem[CREDIT_W-1:0];
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == VEND) || (state_n == CHANGE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            credit         <= '0;
            remainder      <= '0;
            vend_valid     <= '0;
            change_quarter <= 1'b0;
            change_dime    <= 1'b0;
            change_nickel  <= 1'b0;
            coin_reject    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            credit         <= credit_n;
            remainder      <= remainder_n;
            vend_valid     <= vend_n;
            change_quarter <= cq_n;
            change_dime    <= cd_n;
            change_nickel  <= cn_n;
            coin_reject    <= reject_n;
            busy           <= busy_n;
        end
    end

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed self-checking bench for vend_fsm_param (default parameters; refund scenario with REFUND_EN).
module tb_vend_fsm_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_nickel, coin_dime, coin_quarter;
    logic [1:0] sel;
    logic       refund;
    logic [1:0] vend_valid;
    logic       change_nickel, change_dime, change_quarter;
    logic       coin_reject;
    logic [4:0] credit;
    logic       busy;

    int passed = 0;
    int total  = 0;

    vend_fsm_param #(.NUM_PRODUCTS(2), .PRICE(9), .MAX_CREDIT(20), .CREDIT_W(5)) dut (
        .clk(clk),
        .reset(reset),
        .coin_nickel(coin_nickel),
        .coin_dime(coin_dime),
        .coin_quarter(coin_quarter),
        .sel(sel),
`ifdef REFUND_EN
        .refund(refund),
`endif
        .vend_valid(vend_valid),
        .change_nickel(change_nickel),
        .change_dime(change_dime),
        .change_quarter(change_quarter),
        .coin_reject(coin_reject),
        .credit(credit),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic n, input logic d, input logic q);
        coin_nickel = n; coin_dime = d; coin_quarter = q;
        tick();
        coin_nickel = 0; coin_dime = 0; coin_quarter = 0;
    endtask

    task automatic test_reset();
        reset = 1; coin_nickel = 0; coin_dime = 0; coin_quarter = 0; sel = 0; refund = 0;
        tick(); tick();
        total++;
        if ({vend_valid, change_quarter, change_dime, change_nickel, coin_reject, busy, credit} !== 12'd0)
            $display("FAIL reset_outputs: got vend=%b cq=%b cd=%b cn=%b rej=%b busy=%b credit=%0d, want all 0",
                     vend_valid, change_quarter, change_dime, change_nickel, coin_reject, busy, credit);
        else passed++;
        reset = 0;
        tick();
    endtask

    task automatic test_exact_vend();
        coin(0, 0, 1); coin(0, 1, 0); coin(0, 1, 0);
        total++;
        if (credit !== 5'd9) $display("FAIL exact_credit: got %0d want 9", credit); else passed++;
        sel = 2'b01; coin_nickel = 1;
        tick();
        sel = 0; coin_nickel = 0;
        total++;
        if ({vend_valid, coin_reject, busy, credit} !== {2'b01, 1'b1, 1'b1, 5'd0})
            $display("FAIL exact_vend: got vend=%b rej=%b busy=%b credit=%0d want vend=01 rej=1 busy=1 credit=0",
                     vend_valid, coin_reject, busy, credit);
        else passed++;
        tick();
        total++;
        if ({vend_valid, change_quarter, change_dime, change_nickel, busy, credit} !== 10'd0)
            $display("FAIL exact_idle: got vend=%b q/d/n=%b%b%b busy=%b credit=%0d want all 0",
                     vend_valid, change_quarter, change_dime, change_nickel, busy, credit);
        else passed++;
    endtask

    task automatic test_vend_change();
        coin(0, 0, 1); coin(0, 0, 1);
        total++;
        if (credit !== 5'd10) $display("FAIL vc_credit: got %0d want 10", credit); else passed++;
        sel = 2'b10;
        tick();
        sel = 0;
        total++;
        if (vend_valid !== 2'b10) $display("FAIL vc_vend: got %b want 10", vend_valid); else passed++;
        coin_dime = 1;
        tick();
        coin_dime = 0;
        total++;
        if ({change_quarter, change_dime, change_nickel, coin_reject, busy, vend_valid} !== {3'b001, 1'b1, 1'b1, 2'b00})
            $display("FAIL vc_change: got q/d/n=%b%b%b rej=%b busy=%b vend=%b want 001 1 1 00",
                     change_quarter, change_dime, change_nickel, coin_reject, busy, vend_valid);
        else passed++;
        tick();
        total++;
        if ({change_quarter, change_dime, change_nickel, coin_reject, busy, credit} !== 10'd0)
            $display("FAIL vc_idle: got q/d/n=%b%b%b rej=%b busy=%b credit=%0d want 0",
                     change_quarter, change_dime, change_nickel, coin_reject, busy, credit);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [2:0] exp_chg [4];
        exp_chg[0] = 3'b100; exp_chg[1] = 3'b100; exp_chg[2] = 3'b001; exp_chg[3] = 3'b000;
        for (int i = 0; i < 4; i++) coin(0, 0, 1);
        total++;
        if (credit !== 5'd20) $display("FAIL ovf_full: got %0d want 20", credit); else passed++;
        coin(0, 0, 1);
        total++;
        if ({coin_reject, credit} !== {1'b1, 5'd20})
            $display("FAIL ovf_reject: got rej=%b credit=%0d want rej=1 credit=20", coin_reject, credit);
        else passed++;
        sel = 2'b01;
        tick();
        sel = 0;
        total++;
        if ({vend_valid, coin_reject, credit} !== {2'b01, 1'b0, 5'd0})
            $display("FAIL ovf_vend: got vend=%b rej=%b credit=%0d want 01 0 0", vend_valid, coin_reject, credit);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({change_quarter, change_dime, change_nickel} !== exp_chg[i])
                $display("FAIL ovf_change%0d: got q/d/n=%b%b%b want %b", i,
                         change_quarter, change_dime, change_nickel, exp_chg[i]);
            else passed++;
        end
        total++;
        if (busy !== 1'b0) $display("FAIL ovf_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_bad_inputs();
        coin(0, 0, 1); coin(0, 0, 1);
        coin(1, 1, 0);
        total++;
        if ({coin_reject, credit} !== {1'b1, 5'd10})
            $display("FAIL multi_coin: got rej=%b credit=%0d want rej=1 credit=10", coin_reject, credit);
        else passed++;
        sel = 2'b11;
        tick();
        total++;
        if ({vend_valid, busy, credit} !== {2'b00, 1'b0, 5'd10})
            $display("FAIL sel_multi: got vend=%b busy=%b credit=%0d want 00 0 10", vend_valid, busy, credit);
        else passed++;
        sel = 2'b00;
        tick();
        total++;
        if ({vend_valid, busy, credit} !== {2'b00, 1'b0, 5'd10})
            $display("FAIL sel_zero: got vend=%b busy=%b credit=%0d want 00 0 10", vend_valid, busy, credit);
        else passed++;
        sel = 2'b01;
        tick();
        sel = 0;
        tick(); tick();
        coin(1, 0, 0);
        sel = 2'b01;
        tick();
        sel = 0;
        total++;
        if ({vend_valid, busy, credit} !== {2'b00, 1'b0, 5'd1})
            $display("FAIL sel_low_credit: got vend=%b busy=%b credit=%0d want 00 0 1", vend_valid, busy, credit);
        else passed++;
        coin(0, 0, 1); coin(0, 1, 0); coin(1, 0, 0);
        sel = 2'b10;
        tick();
        sel = 0;
        total++;
        if (vend_valid !== 2'b10) $display("FAIL low_credit_vend: got %b want 10", vend_valid); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_change();
        for (int i = 0; i < 4; i++) coin(0, 0, 1);
        sel = 2'b01;
        tick();
        sel = 0;
        tick();
        total++;
        if ({change_quarter, busy} !== 2'b11)
            $display("FAIL rst_pre: got cq=%b busy=%b want 1 1", change_quarter, busy);
        else passed++;
        reset = 1;
        #1;
        total++;
        if ({vend_valid, change_quarter, change_dime, change_nickel, coin_reject, busy, credit} !== 12'd0)
            $display("FAIL rst_async: got cq=%b busy=%b credit=%0d want 0", change_quarter, busy, credit);
        else passed++;
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({change_quarter, change_dime, change_nickel, busy, vend_valid, credit} !== 11'd0)
                $display("FAIL rst_quiet%0d: got q/d/n=%b%b%b busy=%b credit=%0d want 0", i,
                         change_quarter, change_dime, change_nickel, busy, credit);
            else passed++;
        end
    endtask

`ifdef REFUND_EN
    task automatic test_refund();
        refund = 1;
        tick();
        refund = 0;
        total++;
        if ({busy, change_quarter, change_dime, change_nickel} !== 4'b0000)
            $display("FAIL refund_idle: got busy=%b q/d/n=%b%b%b want 0", busy, change_quarter, change_dime, change_nickel);
        else passed++;
        coin(0, 0, 1); coin(0, 1, 0);
        total++;
        if (credit !== 5'd7) $display("FAIL refund_credit: got %0d want 7", credit); else passed++;
        refund = 1;
        tick();
        refund = 0;
        total++;
        if ({change_quarter, change_dime, change_nickel, busy, credit} !== {3'b100, 1'b1, 5'd0})
            $display("FAIL refund_q: got q/d/n=%b%b%b busy=%b credit=%0d want 100 1 0",
                     change_quarter, change_dime, change_nickel, busy, credit);
        else passed++;
        coin_dime = 1;
        tick();
        coin_dime = 0;
        total++;
        if ({change_quarter, change_dime, change_nickel, coin_reject, credit} !== {3'b010, 1'b1, 5'd0})
            $display("FAIL refund_d: got q/d/n=%b%b%b rej=%b credit=%0d want 010 1 0",
                     change_quarter, change_dime, change_nickel, coin_reject, credit);
        else passed++;
        tick();
        total++;
        if ({change_quarter, change_dime, change_nickel, busy, credit} !== 9'd0)
            $display("FAIL refund_idle_end: got q/d/n=%b%b%b busy=%b credit=%0d want 0",
                     change_quarter, change_dime, change_nickel, busy, credit);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_exact_vend();
        test_vend_change();
        test_overflow();
        test_bad_inputs();
        test_reset_mid_change();
`ifdef REFUND_EN
        test_refund();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
